// File: rtl/ts_qos_pkg.sv
// Shared definitions for the QoS transport-stream path.
// Holds TS packet constants, the output-switch state enum and the channel index type.
package ts_qos_pkg;

  localparam int unsigned TS_PKT_LEN   = 188;
  localparam int unsigned TS_NUM_CH    = 4;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

  typedef enum logic {
    ACQUIRE = 1'b0,
    PASS    = 1'b1
  } ts_state_e;

  typedef logic [1:0] ts_ch_t;

endpackage

// File: rtl/ts_output_switch.sv
// TS output stage: forwards one of four sync-recovered TS streams to the single
// TS output, changing source only on packet boundaries so every emitted packet
// is whole. A stalled source with a pending switch is abandoned after TIMEOUT_CYC
// idle cycles.
//
// Ports:
//   clk, rst          stream clock, asynchronous active-high reset
//   sel               requested channel (0..3)
//   valid_in/sync_in  per-channel byte valid / first-byte-of-packet flag
//   data_in0..3       per-channel byte
//   valid_out/syn_out output byte valid / first byte of output packet
//   ts_data_out       output byte (held while valid_out is low)
//   active_sel        channel currently forwarded
//   switch_pending    sel != active_sel (combinational)
//   switch_done       one-cycle pulse when active_sel changes
//   trunc_err         one-cycle pulse when an output packet ends short
module ts_output_switch
  import ts_qos_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PKT_LEN     = TS_PKT_LEN,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            sel,
  input  logic [3:0]            valid_in,
  input  logic [3:0]            sync_in,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  output logic                  valid_out,
  output logic                  syn_out,
  output logic [DATA_WIDTH-1:0] ts_data_out,
  output logic [1:0]            active_sel,
  output logic                  switch_pending,
  output logic                  switch_done,
  output logic                  trunc_err
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(PKT_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  ts_state_e             state_q,    state_d;
  ts_ch_t                active_q,   active_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0]     idle_q,     idle_d;
  logic                  valid_q,    valid_d;
  logic                  syn_q,      syn_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic                  done_q,     done_d;
  logic                  trunc_q,    trunc_d;

  logic [DATA_WIDTH-1:0] mux_data;
  logic                  a_valid;
  logic                  a_sync;
  logic                  pending;

  // 4:1 byte mux on the active channel
  always_comb begin
    mux_data = data_in0;
    case (active_q)
      2'd1:    mux_data = data_in1;
      2'd2:    mux_data = data_in2;
      2'd3:    mux_data = data_in3;
      default: mux_data = data_in0;
    endcase
  end

  assign a_valid = valid_in[active_q];
  assign a_sync  = sync_in[active_q];
  assign pending = (sel != active_q);

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    byte_cnt_d = byte_cnt_q;
    idle_d     = '0;
    valid_d    = 1'b0;
    syn_d      = 1'b0;
    data_d     = data_q;
    done_d     = 1'b0;
    trunc_d    = 1'b0;

    case (state_q)
      ACQUIRE: begin
        byte_cnt_d = '0;
        if (pending) begin
          active_d = sel;
          done_d   = 1'b1;
        end else if (a_valid && a_sync) begin
          valid_d    = 1'b1;
          syn_d      = 1'b1;
          data_d     = mux_data;
          byte_cnt_d = CNT_W'(1);
          state_d    = PASS;
        end
      end

      PASS: begin
        if (byte_cnt_q == '0) begin
          // Packet boundary: switch first, otherwise expect a new sync
          if (pending) begin
            active_d = sel;
            done_d   = 1'b1;
            state_d  = ACQUIRE;
          end else if (a_valid) begin
            if (a_sync) begin
              valid_d    = 1'b1;
              syn_d      = 1'b1;
              data_d     = mux_data;
              byte_cnt_d = CNT_W'(1);
            end else begin
              state_d = ACQUIRE;
            end
          end
        end else if (a_valid) begin
          valid_d = 1'b1;
          syn_d   = a_sync;
          data_d  = mux_data;
          if (a_sync) begin
            // Early sync restarts the packet; the previous one was short
            trunc_d    = 1'b1;
            byte_cnt_d = CNT_W'(1);
          end else if (byte_cnt_q == LAST_BYTE) begin
            // Completing byte: a switch pending now is taken this cycle
            byte_cnt_d = '0;
            if (pending) begin
              active_d = sel;
              done_d   = 1'b1;
              state_d  = ACQUIRE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end else if (pending) begin
          // Stalled mid-packet with a switch waiting: force it after the timeout
          if (idle_q == IDLE_LAST) begin
            active_d   = sel;
            done_d     = 1'b1;
            trunc_d    = 1'b1;
            byte_cnt_d = '0;
            state_d    = ACQUIRE;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end

      default: state_d = ACQUIRE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACQUIRE;
      active_q   <= '0;
      byte_cnt_q <= '0;
      idle_q     <= '0;
      valid_q    <= 1'b0;
      syn_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      byte_cnt_q <= byte_cnt_d;
      idle_q     <= idle_d;
      valid_q    <= valid_d;
      syn_q      <= syn_d;
      data_q     <= data_d;
      done_q     <= done_d;
      trunc_q    <= trunc_d;
    end
  end

  assign valid_out      = valid_q;
  assign syn_out        = syn_q;
  assign ts_data_out    = data_q;
  assign active_sel     = active_q;
  assign switch_pending = pending;
  assign switch_done    = done_q;
  assign trunc_err      = trunc_q;

endmodule

// File: doc/ts_output_switch.md
# ts_output_switch

Output stage of the QoS transport-stream path: consumes the four sync-recovered 188-byte TS streams and the 2-bit channel select from main control, and drives the single TS output (`valid_out`, `syn_out`, `ts_data_out`). Changes of source take effect only on packet boundaries, so every emitted packet is whole and starts with its sync byte. A stalled source is abandoned after a programmable timeout.

## Interface
Parameters:
- `DATA_WIDTH`, 8, TS byte width
- `PKT_LEN`, 188, bytes per TS packet
- `TIMEOUT_CYC`, 1024, idle cycles on the active channel before a pending switch is forced

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: stream clock (the FIFO read clock)
- `rst` in 1: asynchronous, active-high reset
- `sel` in 2: requested channel, 0..3 (main control `mux_control`)
- `valid_in` in 4: per-channel byte valid; bit i = channel i
- `sync_in` in 4: per-channel sync flag, high with the first byte of a packet
- `data_in0`..`data_in3` in DATA_WIDTH each: per-channel byte
- `valid_out` out 1: output byte valid
- `syn_out` out 1: high with the first byte of each output packet
- `ts_data_out` out DATA_WIDTH: output byte
- `active_sel` out 2: channel currently forwarded
- `switch_pending` out 1: `sel != active_sel`
- `switch_done` out 1: one-cycle pulse when `active_sel` is updated
- `trunc_err` out 1: one-cycle pulse when an output packet ends short (early sync or forced switch)

## Operation
- State machine with two states:
  - `ACQUIRE` is the reset state. No output. Waits for `valid_in[a] & sync_in[a]` on the active channel a. That byte is forwarded with `syn_out=1`, `byte_cnt` is set to 1, and the state moves to `PASS`.
  - `PASS` forwards each valid byte of channel a. `syn_out = sync_in[a]`.
- `byte_cnt` is 8 bits, range 0..PKT_LEN-1. It increments on every forwarded byte and wraps to 0 after the PKT_LEN-th byte. `byte_cnt==0` in `PASS` is a packet boundary.
- Events in `PASS`:
  - At the boundary, a sync byte is forwarded as the next packet.
  - At the boundary, a non-sync valid byte is dropped and the state moves to `ACQUIRE` (loss of lock).
  - A sync byte arriving mid-packet (`byte_cnt != 0`) is forwarded, `byte_cnt` is set to 1, and `trunc_err` pulses.
- Switching:
  - When `switch_pending` is high and the state is at a boundary, `active_sel <= sel`, the state moves to `ACQUIRE`, and `switch_done` pulses.
  - If the byte that completes a packet arrives in the same cycle that `sel` changes, that byte is forwarded and the switch happens in that cycle.
  - In `ACQUIRE`, a pending switch is taken immediately.
  - If `sel` returns to `active_sel` before the boundary, the pending switch is cancelled and no pulse occurs.
- Stall timeout:
  - `idle_cnt` counts consecutive cycles without `valid_in[a]` while `PASS` is mid-packet and `switch_pending` is high. Any other condition clears it.
  - When `idle_cnt` reaches TIMEOUT_CYC, the switch is forced: `trunc_err` and `switch_done` pulse, and the state moves to `ACQUIRE` on the new channel.
- Bytes on non-active channels are always ignored.

## Timing
- All outputs are registered. Latency from input byte to output byte is 1 cycle. There is no backpressure.
- Reset values: `valid_out`, `syn_out`, `switch_done`, `trunc_err` = 0; `ts_data_out` = 0; `active_sel` = 0; state = `ACQUIRE`; `byte_cnt` = `idle_cnt` = 0.
- `switch_pending` is combinational from `sel` and `active_sel`.
- `ts_data_out` is held (not zeroed) when `valid_out` = 0.
- Reset asserted mid-packet abandons the packet with no `trunc_err`. After reset is released, output resumes only at the next sync on channel 0.
- Minimum gap from `switch_done` to the first new-channel output byte is 1 cycle.

## Structure
- Shared package `ts_qos_pkg` holds:
  - `TS_PKT_LEN = 188`
  - `TS_SYNC_BYTE = 8'h47`
  - the state enum `{ACQUIRE, PASS}`
  - the channel-index type (2 bits)
- Single flat module. The 4:1 byte mux is inline. No sub-module is required.

## Test plan
- Reset released; channel 0 sends three back-to-back 188-byte packets starting with 0x47. Required: 564 output bytes, `syn_out` high exactly at bytes 1, 189 and 377, each output 1 cycle after its input.
- `sel` changes 0→2 at byte 50 of a channel-0 packet. Required: the remaining 138 channel-0 bytes are output, `switch_done` pulses after byte 188, the next output is the first channel-2 sync byte, and there is no `trunc_err`.
- `sel` changes 0→1 at byte 10 and back 1→0 at byte 100. Required: no `switch_done`, `active_sel` stays 0, and the stream is uninterrupted.
- `sel` changes to 3 at byte 20, then channel 0 stops with TIMEOUT_CYC=16. Required: `trunc_err` and `switch_done` pulse 16 cycles after the last channel-0 byte, and output resumes at the next channel-3 sync.
- Channel 0 sends a sync at byte 100 of a packet. Required: `trunc_err` pulses, `syn_out`=1 on that byte, and the next boundary falls 188 bytes later.
- Reset asserted at byte 90. Required: all outputs 0 next cycle, and channel 0 is re-acquired only at its next sync byte.
